// File: rtl/cache_pkg.sv
// Shared widths, timing constants and controller state type for the data-memory subsystem.
package cache_pkg;

    localparam int unsigned ADDR_W       = 10;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned BLOCK_WORDS  = 4;
    localparam int unsigned CACHE_BLOCKS = 32;
    localparam int unsigned OFFSET_W     = 2;
    localparam int unsigned INDEX_W      = 5;
    localparam int unsigned TAG_W        = ADDR_W - OFFSET_W - INDEX_W;
    localparam int unsigned MEM_LAT      = 4;
    localparam int unsigned CNT_W        = $clog2(MEM_LAT);

    typedef logic [BLOCK_WORDS-1:0][DATA_W-1:0] block_t;

    typedef enum logic [1:0] {
        StIdle,
        StReadMiss,
        StWriteMem
    } state_e;

endpackage

// File: rtl/main_memory.sv
// Main memory: word-addressed array with a fixed access latency, a block read
// port and a word write port. ready_o pulses on the last latency cycle.
module main_memory
    import cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              ready_o,
    output block_t            block_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(MEM_LAT - 1);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [CNT_W-1:0]  cnt_q;

    assign ready_o = req_i && (cnt_q == CntLast);

    // Latency counter: runs while a request is held, wraps on completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (ready_o) begin
            cnt_q <= '0;
        end else if (req_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Storage: zeroed by reset, written only when the access completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < 2**ADDR_W; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ready_o && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Block read: the four words of the block containing addr_i.
    always_comb begin
        block_o = '0;
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            block_o[k] = mem_q[{addr_i[ADDR_W-1:OFFSET_W], OFFSET_W'(k)}];
        end
    end

endmodule

// File: rtl/cache_integration.sv
// Direct-mapped, write-through, no-write-allocate data cache with its
// controller FSM in front of a multi-cycle main memory.
module cache_integration
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data_in_CPU,
    output logic [DATA_W-1:0] Data_out_cpu,
    output logic              stall
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    block_t              line_data_q [CACHE_BLOCKS];
    logic [TAG_W-1:0]    line_tag_q  [CACHE_BLOCKS];
    logic [CACHE_BLOCKS-1:0] line_valid_q;

    logic [TAG_W-1:0]    tag_in, tag_q;
    logic [INDEX_W-1:0]  idx_in, idx_q;
    logic [OFFSET_W-1:0] off_in, off_q;
    logic                hit_in, hit_q;
    logic [DATA_W-1:0]   word_in;

    logic   mem_req, mem_we, mem_ready;
    block_t mem_block;

    assign {tag_in, idx_in, off_in} = Address;
    assign {tag_q, idx_q, off_q}    = addr_q;

    assign hit_in  = line_valid_q[idx_in] && (line_tag_q[idx_in] == tag_in);
    assign hit_q   = line_valid_q[idx_q] && (line_tag_q[idx_q] == tag_q);
    assign word_in = line_data_q[idx_in][off_in];

    assign mem_req = (state_q != StIdle);
    assign mem_we  = (state_q == StWriteMem);

    // Stall is combinational so the IDLE decision cycle already freezes the CPU.
    always_comb begin
        stall        = 1'b1;
        Data_out_cpu = rdata_q;
        if (state_q == StIdle) begin
            stall = MemWrite || (MemRead && !hit_in);
            if (!MemWrite && MemRead && hit_in) begin
                Data_out_cpu = word_in;
            end
        end
    end

    // Controller: latches the request on leaving IDLE and waits for memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (MemWrite) begin
                        addr_q  <= Address;
                        wdata_q <= Data_in_CPU;
                        state_q <= StWriteMem;
                    end else if (MemRead) begin
                        if (hit_in) begin
                            rdata_q <= word_in;
                        end else begin
                            addr_q  <= Address;
                            state_q <= StReadMiss;
                        end
                    end
                end
                StReadMiss: begin
                    if (mem_ready) begin
                        rdata_q <= mem_block[off_q];
                        state_q <= StIdle;
                    end
                end
                StWriteMem: begin
                    if (mem_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Valid bits: set by a completed fill, all cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_valid_q <= '0;
        end else if (state_q == StReadMiss && mem_ready) begin
            line_valid_q[idx_q] <= 1'b1;
        end
    end

    // Line data and tags: whole-line fill on read miss, single word on write hit.
    always_ff @(posedge clk) begin
        if (state_q == StReadMiss && mem_ready) begin
            line_data_q[idx_q] <= mem_block;
            line_tag_q[idx_q]  <= tag_q;
        end else if (state_q == StWriteMem && mem_ready && hit_q) begin
            line_data_q[idx_q][off_q] <= wdata_q;
        end
    end

    main_memory u_mem (
        .clk_i   (clk),
        .rst_ni  (rst),
        .req_i   (mem_req),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .ready_o (mem_ready),
        .block_o (mem_block)
    );

endmodule

// File: tb/tb_cache_integration.sv
// Directed bench for cache_integration: write-through misses/hits, read
// fills, conflict refill, read/write priority and reset during a stall.
module tb_cache_integration;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic        MemRead;
    logic [9:0]  Address;
    logic [31:0] Data_in_CPU;
    logic [31:0] Data_out_cpu;
    logic        stall;

    int total = 0;
    int bad   = 0;
    int cycles;
    logic [31:0] dec_data;
    logic [31:0] end_data;

    cache_integration dut (
        .clk          (clk),
        .rst          (rst),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .Address      (Address),
        .Data_in_CPU  (Data_in_CPU),
        .Data_out_cpu (Data_out_cpu),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One request: applied for the decision cycle, then dropped; the design
    // works from its registered copies. Counts cycles with stall high.
    task automatic access(input logic we, input logic re, input logic [9:0] addr,
                          input logic [31:0] data);
        @(negedge clk);
        MemWrite    = we;
        MemRead     = re;
        Address     = addr;
        Data_in_CPU = data;
        #1;
        cycles   = stall ? 1 : 0;
        dec_data = Data_out_cpu;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        while (stall && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        end_data = Data_out_cpu;
    endtask

    initial begin
        logic [31:0] wr_vals [3];
        wr_vals[0] = 32'd2;
        wr_vals[1] = 32'd3;
        wr_vals[2] = 32'd4;

        rst = 1'b0;
        MemWrite = 1'b0;
        MemRead = 1'b0;
        Address = '0;
        Data_in_CPU = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_dout", Data_out_cpu, 32'd0);
        check("rst_valid", dut.line_valid_q, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Write miss: memory updated, no allocation.
        access(1'b1, 1'b0, 10'd128, 32'd1);
        check("wmiss_cycles", cycles, 32'd5);
        check("wmiss_mem", dut.u_mem.mem_q[128], 32'd1);
        check("wmiss_noalloc", {31'd0, dut.line_valid_q[0]}, 32'd0);

        for (int i = 0; i < 3; i++) begin
            access(1'b1, 1'b0, 10'(129 + i), wr_vals[i]);
            check("wr_cycles", cycles, 32'd5);
            check("wr_mem", dut.u_mem.mem_q[129 + i], wr_vals[i]);
        end

        // Read miss fills line 0 with tag 1.
        access(1'b0, 1'b1, 10'd128, 32'd0);
        check("rmiss_cycles", cycles, 32'd5);
        check("rmiss_data", end_data, 32'd1);
        check("rmiss_valid", {31'd0, dut.line_valid_q[0]}, 32'd1);
        check("rmiss_tag", {29'd0, dut.line_tag_q[0]}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            access(1'b0, 1'b1, 10'(129 + i), 32'd0);
            check("rhit_cycles", cycles, 32'd0);
            check("rhit_data", dec_data, wr_vals[i]);
        end

        // Idle output holds the last read value.
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold", Data_out_cpu, 32'd4);

        // Write hit updates both memory and cache.
        access(1'b1, 1'b0, 10'd130, 32'd15);
        check("whit_cycles", cycles, 32'd5);
        check("whit_mem", dut.u_mem.mem_q[130], 32'd15);
        access(1'b0, 1'b1, 10'd130, 32'd0);
        check("whit_rd_cycles", cycles, 32'd0);
        check("whit_rd_data", dec_data, 32'd15);

        // Conflict: address 0 shares index 0, different tag.
        access(1'b0, 1'b1, 10'd0, 32'd0);
        check("conf_cycles", cycles, 32'd5);
        check("conf_data", end_data, 32'd0);
        check("conf_tag", {29'd0, dut.line_tag_q[0]}, 32'd0);
        access(1'b0, 1'b1, 10'd128, 32'd0);
        check("conf_back_cycles", cycles, 32'd5);
        check("conf_back_data", end_data, 32'd1);

        // Read and write together act as a write.
        access(1'b1, 1'b1, 10'd5, 32'hAB);
        check("rw_cycles", cycles, 32'd5);
        check("rw_mem", dut.u_mem.mem_q[5], 32'hAB);
        access(1'b0, 1'b1, 10'd5, 32'd0);
        check("rw_rd_cycles", cycles, 32'd5);
        check("rw_rd_data", end_data, 32'hAB);

        // Reset in the middle of a read miss.
        @(negedge clk);
        MemRead = 1'b1;
        Address = 10'd256;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_valid", dut.line_valid_q, 32'd0);
        check("mid_rst_dout", Data_out_cpu, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        access(1'b0, 1'b1, 10'd128, 32'd0);
        check("post_rst_cycles", cycles, 32'd5);
        check("post_rst_data", end_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
